// File: rtl/tetris_grid_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tetris_grid_renderer
//  Purpose  : Turns a per-frame snapshot of the 20x10 playfield into 12-bit RGB
//             pixels (2-cycle pipeline, well border, gameover blink).
//  Revision : 1.0 - initial release
// ============================================================================
module tetris_grid_renderer #(
    parameter int CELL_PX      = 16,
    parameter int GRID_X0      = 240,
    parameter int GRID_Y0      = 80,
    parameter int BORDER_PX    = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [199:0] display_array_i,
    input  logic         gameover_i,
    input  logic [9:0]   hcount_i,
    input  logic [9:0]   vcount_i,
    input  logic         pix_valid_i,
    input  logic         frame_start_i,
    output logic [3:0]   red_o,
    output logic [3:0]   green_o,
    output logic [3:0]   blue_o,
    output logic         pix_valid_o,
    output logic         blink_phase_o
);

    localparam int               c_SHIFT      = $clog2(CELL_PX);
    localparam logic signed [10:0] c_GRID_W   = 11'(10 * CELL_PX);
    localparam logic signed [10:0] c_GRID_H   = 11'(20 * CELL_PX);
    localparam logic signed [10:0] c_BMIN     = 11'(-BORDER_PX);
    localparam logic signed [10:0] c_BXMAX    = 11'(10 * CELL_PX + BORDER_PX);
    localparam logic signed [10:0] c_BYMAX    = 11'(20 * CELL_PX + BORDER_PX);
    localparam logic [7:0]         c_BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [199:0] r_snap;
    logic         r_go_snap;
    logic [7:0]   r_blink_cnt;
    logic         r_blink_phase;

    // Counting only begins on the second gameover pulse so the first
    // gameover frame is the first of a full "shown" half-period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap        <= '0;
            r_go_snap     <= 1'b0;
            r_blink_cnt   <= 8'd0;
            r_blink_phase <= 1'b1;
        end else if (frame_start_i) begin
            r_snap    <= display_array_i;
            r_go_snap <= gameover_i;
            if (!gameover_i || !r_go_snap) begin
                r_blink_cnt   <= 8'd0;
                r_blink_phase <= 1'b1;
            end else if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt   <= 8'd0;
                r_blink_phase <= !r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
            end
        end
    end

    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    logic               w_in_grid;
    logic               w_in_border;
    logic               w_edge;
    logic [4:0]         w_row;
    logic [3:0]         w_col;

    assign w_dx = $signed({1'b0, hcount_i}) - $signed(11'(GRID_X0));
    assign w_dy = $signed({1'b0, vcount_i}) - $signed(11'(GRID_Y0));

    assign w_in_grid   = (w_dx >= 11'sd0) && (w_dx < c_GRID_W) &&
                         (w_dy >= 11'sd0) && (w_dy < c_GRID_H);
    assign w_in_border = !w_in_grid &&
                         (w_dx >= c_BMIN) && (w_dx < c_BXMAX) &&
                         (w_dy >= c_BMIN) && (w_dy < c_BYMAX);
    assign w_edge      = w_in_grid && ((w_dx[c_SHIFT-1:0] == '0) ||
                                       (w_dy[c_SHIFT-1:0] == '0));
    // Row/col forced to 0 outside the grid keeps the snapshot index in range.
    assign w_row = w_in_grid ? 5'(w_dy[9:0] >> c_SHIFT) : 5'd0;
    assign w_col = w_in_grid ? 4'(w_dx[9:0] >> c_SHIFT) : 4'd0;

    logic       r1_valid;
    logic       r1_in_grid;
    logic       r1_in_border;
    logic       r1_edge;
    logic [4:0] r1_row;
    logic [3:0] r1_col;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1_valid     <= 1'b0;
            r1_in_grid   <= 1'b0;
            r1_in_border <= 1'b0;
            r1_edge      <= 1'b0;
            r1_row       <= 5'd0;
            r1_col       <= 4'd0;
        end else begin
            r1_valid     <= pix_valid_i;
            r1_in_grid   <= w_in_grid;
            r1_in_border <= w_in_border;
            r1_edge      <= w_edge;
            r1_row       <= w_row;
            r1_col       <= w_col;
        end
    end

    logic [7:0]  w_idx;
    logic        w_filled;
    logic [11:0] w_rgb;

    assign w_idx    = 8'(r1_row) * 8'd10 + 8'(r1_col);
    assign w_filled = r_snap[w_idx];

    always_comb begin
        w_rgb = 12'h000;
        if (!r1_valid) begin
            w_rgb = 12'h000;
        end else if (r1_in_border) begin
            w_rgb = 12'h888;
        end else if (r1_in_grid && w_filled && (!r_go_snap || r_blink_phase)) begin
            w_rgb = r_go_snap ? 12'hF00 : 12'hFFF;
        end else if (r1_edge) begin
            w_rgb = 12'h222;
        end
    end

    logic [11:0] r_rgb;
    logic        r_valid2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgb    <= 12'h000;
            r_valid2 <= 1'b0;
        end else begin
            r_rgb    <= w_rgb;
            r_valid2 <= r1_valid;
        end
    end

    assign red_o         = r_rgb[11:8];
    assign green_o       = r_rgb[7:4];
    assign blue_o        = r_rgb[3:0];
    assign pix_valid_o   = r_valid2;
    assign blink_phase_o = r_blink_phase;

endmodule
`default_nettype wire

// File: tb/tb_tetris_grid_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tetris_grid_renderer
//  Purpose  : Directed + randomized bench for tetris_grid_renderer against a
//             pixel-geometry reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_grid_renderer;

    logic         clk = 1'b0;
    logic         rst;
    logic [199:0] disp;
    logic         go;
    logic         pv;
    logic         fs;
    logic [9:0]   hc;
    logic [9:0]   vc;
    logic [3:0]   red;
    logic [3:0]   green;
    logic [3:0]   blue;
    logic         pvo;
    logic         ph;

    always #5 clk = ~clk;

    tetris_grid_renderer dut (
        .clk             (clk),
        .rst             (rst),
        .display_array_i (disp),
        .gameover_i      (go),
        .hcount_i        (hc),
        .vcount_i        (vc),
        .pix_valid_i     (pv),
        .frame_start_i   (fs),
        .red_o           (red),
        .green_o         (green),
        .blue_o          (blue),
        .pix_valid_o     (pvo),
        .blink_phase_o   (ph)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference state: field as latched, gameover as latched, frames since entering gameover.
    logic [199:0] m_snap;
    bit           m_go;
    int           m_k;

    typedef struct {
        logic [11:0] rgb;
        logic        pv;
    } exp_t;
    exp_t q[$];

    function automatic bit m_phase();
        return !m_go || ((m_k / 30) % 2 == 0);
    endfunction

    function automatic logic [11:0] m_rgb(bit v, int x, int y);
        int dx = x - 240;
        int dy = y - 80;
        bit ig;
        bit ib;
        if (!v) return 12'h000;
        ig = dx >= 0 && dx < 160 && dy >= 0 && dy < 320;
        ib = !ig && dx >= -4 && dx < 164 && dy >= -4 && dy < 324;
        if (ib) return 12'h888;
        if (ig) begin
            if (m_snap[(dy / 16) * 10 + dx / 16] && m_phase())
                return m_go ? 12'hF00 : 12'hFFF;
            if (dx % 16 == 0 || dy % 16 == 0) return 12'h222;
        end
        return 12'h000;
    endfunction

    task automatic check(string tag, logic [11:0] obs, logic [11:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One clock of stimulus; outputs are checked for the pixel driven one step earlier.
    task automatic step(bit v, int x, int y, bit f);
        exp_t e;
        exp_t p;
        pv = v;
        hc = 10'(x);
        vc = 10'(y);
        fs = f;
        if (f) begin
            if (go) begin
                if (m_go) m_k++;
                else m_k = 0;
            end
            m_go   = go;
            m_snap = disp;
        end
        e.rgb = m_rgb(v, x, y);
        e.pv  = v;
        @(posedge clk);
        @(negedge clk);
        fs = 1'b0;
        if (q.size() > 0) begin
            p = q.pop_front();
            check("rgb", {red, green, blue}, p.rgb);
            check("pix_valid_o", {11'd0, pvo}, {11'd0, p.pv});
        end
        check("blink_phase", {11'd0, ph}, {11'd0, m_phase()});
        q.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        pv  = 1'b1;
        hc  = 10'd250;
        vc  = 10'd90;
        m_snap = '0;
        m_go   = 1'b0;
        m_k    = 0;
        q.delete();
        repeat (3) begin
            @(negedge clk);
            check("rst_rgb", {red, green, blue}, 12'h000);
            check("rst_pv", {11'd0, pvo}, 12'h000);
            check("rst_phase", {11'd0, ph}, 12'h001);
        end
        rst = 1'b1;
    endtask

    initial begin
        rst  = 1'b1;
        disp = '0;
        go   = 1'b0;
        pv   = 1'b0;
        fs   = 1'b0;
        hc   = '0;
        vc   = '0;
        apply_reset();

        // Cell [0][0] after a frame pulse.
        disp[0] = 1'b1;
        step(0, 0, 0, 1);
        step(1, 245, 85, 0);
        step(1, 261, 85, 0);
        check("cell00", {red, green, blue}, 12'hFFF);
        step(0, 0, 0, 0);
        check("cell01", {red, green, blue}, 12'h000);

        // Field change without a pulse must not show.
        disp[199] = 1'b1;
        step(1, 395, 395, 0);
        step(0, 0, 0, 0);
        check("no_tear", {red, green, blue}, 12'h000);
        step(0, 0, 0, 1);
        step(1, 395, 395, 0);
        step(0, 0, 0, 0);
        check("after_pulse", {red, green, blue}, 12'hFFF);

        // Border and edge pixels.
        step(1, 238, 100, 0);
        step(1, 235, 100, 0);
        check("border", {red, green, blue}, 12'h888);
        step(1, 256, 96, 0);
        check("outside", {red, green, blue}, 12'h000);
        step(0, 0, 0, 0);
        check("edge", {red, green, blue}, 12'h222);

        // Random fields and random pixels around the well.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 200; i++) disp[i] = 1'($urandom_range(0, 1));
            step(0, 0, 0, 1);
            for (int i = 0; i < 40; i++)
                step(($urandom_range(0, 7) != 0), int'($urandom_range(220, 420)),
                     int'($urandom_range(60, 420)), 0);
            step(0, 0, 0, 0);
        end

        // Gameover blink on cell [5][5].
        disp = '0;
        disp[55] = 1'b1;
        go = 1'b1;
        for (int f = 0; f < 65; f++) begin
            step(0, 0, 0, 1);
            step(1, 328, 168, 0);
            step(1, 320, 160, 0);
            check("blink_interior", {red, green, blue},
                  ((f / 30) % 2 == 0) ? 12'hF00 : 12'h000);
            step(1, 336, 168, 0);
            step(0, 0, 0, 0);
        end
        go = 1'b0;
        step(0, 0, 0, 1);
        step(1, 328, 168, 0);
        step(0, 0, 0, 0);

        // Back-to-back stream along the top row.
        disp = '0;
        for (int i = 0; i < 200; i += 3) disp[i] = 1'b1;
        step(0, 0, 0, 1);
        for (int x = 240; x <= 400; x++) step(1, x, 80, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Reset mid-frame clears the snapshot; border still drawn.
        apply_reset();
        step(1, 245, 85, 0);
        step(1, 238, 100, 0);
        check("post_rst_cell", {red, green, blue}, 12'h000);
        step(0, 0, 0, 0);
        check("post_rst_border", {red, green, blue}, 12'h888);
        step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
